// File: rtl/conv_result_reader_if.sv
// Valid/ready result stream from conv_result_reader to its consumer.
interface conv_result_reader_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/conv_result_reader.sv
// Streams the convolution result region (base, len) out of memory as a valid/ready burst.
// Optional running checksum of streamed words: define CONV_READER_CHECKSUM_EN.
module conv_result_reader #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base,
    input  logic [ADDR_W-1:0]    len,
    output logic [ADDR_W-1:0]    rd_index,
    output logic                 rd_en,
    input  logic [DATA_W-1:0]    rd_data,
    conv_result_reader_if.master out_if,
    output logic                 busy,
    output logic                 finished,
    output logic [DATA_W-1:0]    checksum
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, len_q, len_d;
    logic [ADDR_W-1:0] issued_q, issued_d, popped_q, popped_d;
    logic              busy_q, busy_d, finished_q, finished_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [1:0]        count_q;
    logic              wr_ptr_q, rd_ptr_q, inflight_q;
    logic              pop, push, fifo_pop;
    logic [2:0]        occ_after;

    // The word in flight is presented straight from rd_data while the FIFO is empty;
    // it is still captured into the FIFO if not taken, so a stalled word stays stable.
    assign out_if.out_valid = (count_q != 2'd0) | inflight_q;
    assign out_if.out_data  = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : rd_data;
    assign out_if.out_last  = out_if.out_valid & (popped_q == len_q - ADDR_W'(1));

    assign pop       = out_if.out_valid & out_if.out_ready;
    assign fifo_pop  = pop & (count_q != 2'd0);
    assign push      = inflight_q & ~(pop & (count_q == 2'd0));
    assign occ_after = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign rd_index  = base_q + issued_q;
    assign busy      = busy_q;
    assign finished  = finished_q;

    // Next-state, read issue and counters.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = pop ? popped_q + ADDR_W'(1) : popped_q;
        rd_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base;
                    len_d    = len;
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (len == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                if (occ_after < 3'd2) begin
                    rd_en    = 1'b1;
                    issued_d = issued_q + ADDR_W'(1);
                    if (issued_d == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ_after == 3'd0) state_d = S_FIN;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d == S_READ) || (state_d == S_DRAIN);
        finished_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

    // Two-entry skid FIFO plus the single outstanding memory read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q    <= count_q + {1'b0, push} - {1'b0, fifo_pop};
            inflight_q <= rd_en;
        end
    end

`ifdef CONV_READER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (start && (state_q == S_IDLE)) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + out_if.out_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif
endmodule
